// File: rtl/tt_vec_opacc_pkg.sv
// Shared types for the outer-product accumulator sequencer: command opcodes,
// sequencer states and the default tile row count.
package tt_vec_opacc_pkg;

  typedef enum logic [1:0] {
    OPACC_MAC       = 2'd0,
    OPACC_SWAP      = 2'd1,
    OPACC_SWAP_ZERO = 2'd2,
    OPACC_RSVD      = 2'd3
  } opacc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SWAP  = 2'd2,
    ST_FLUSH = 2'd3
  } opacc_state_e;

  localparam int OPACC_MLEN = 256;
  localparam int OPACC_XLEN = 64;
  localparam int ROWS       = OPACC_MLEN / OPACC_XLEN;

endpackage

// File: rtl/tt_vec_opacc_ctrl.sv
// Sequencer for the tt_vec_opacc tile: runs one MAC or SWAP command at a time
// and handshakes the operand-in / result-out streams so no beat is lost or duplicated.
module tt_vec_opacc_ctrl
  import tt_vec_opacc_pkg::*;
#(
  parameter int VLEN  = 256,
  parameter int MLEN  = 256,
  parameter int XLEN  = 64,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_sgn_a,
  input  logic             cmd_sgn_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             en_ab,
  output logic             en_c,
  output logic             issng_a,
  output logic             issng_b,
  output logic             c_zero,
  output logic             busy,
  output logic             done,
  output logic             err_op,
  output logic [1:0]       dbg_state
);

  localparam int ROWS_L = MLEN / XLEN;

  if ((MLEN % XLEN) != 0 || VLEN < XLEN || ROWS_L >= (1 << LEN_W)) begin : g_bad_cfg
    $error("tt_vec_opacc_ctrl: inconsistent VLEN/MLEN/XLEN/LEN_W");
  end

  // Handshakes: a transfer happens on any cycle where valid && ready are both
  // high; valid never waits on ready, and ready may depend combinationally on state.
  opacc_state_e     r_state;
  opacc_op_e        r_op;
  logic [LEN_W-1:0] r_cnt;
  logic             r_sgn_a;
  logic             r_sgn_b;
  logic             r_out_valid;
  logic             r_done;
  logic             r_err_op;

  logic             w_slot_free;
  logic             w_zero;
  logic             w_fire;
  logic             w_mac_beat;
  logic             w_last;
  logic [LEN_W-1:0] w_cnt_dec;
  opacc_op_e        w_cmd_op;

  assign w_cmd_op    = opacc_op_e'(cmd_op);
  assign w_zero      = (r_op == OPACC_SWAP_ZERO);
  // The tile's vo_c register may only be overwritten once its row has been taken.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_fire      = (r_state == ST_SWAP) && w_slot_free && (w_zero || in_valid);
  assign w_mac_beat  = (r_state == ST_MAC) && in_valid;
  assign w_last      = (r_cnt <= LEN_W'(1));
  assign w_cnt_dec   = (r_cnt != '0) ? (r_cnt - LEN_W'(1)) : r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OPACC_MAC;
      r_cnt       <= '0;
      r_sgn_a     <= 1'b0;
      r_sgn_b     <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err_op    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_err_op <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= w_cmd_op;
            r_sgn_a <= cmd_sgn_a;
            r_sgn_b <= cmd_sgn_b;
            case (w_cmd_op)
              OPACC_MAC: begin
                if (cmd_len != '0) begin
                  r_state <= ST_MAC;
                  r_cnt   <= cmd_len;
                end else begin
                  r_done <= 1'b1;
                end
              end
              OPACC_SWAP, OPACC_SWAP_ZERO: begin
                r_state <= ST_SWAP;
                r_cnt   <= LEN_W'(ROWS_L);
              end
              default: begin
                r_done   <= 1'b1;
                r_err_op <= 1'b1;
              end
            endcase
          end
        end
        ST_MAC: begin
          if (w_mac_beat) begin
            r_cnt <= w_cnt_dec;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_SWAP: begin
          if (w_fire) begin
            r_cnt <= w_cnt_dec;
            if (w_last) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (r_out_valid && out_ready) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A fresh shift refills vo_c even if the previous row leaves this cycle.
      if (w_fire)         r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign in_ready  = (r_state == ST_MAC) ||
                     ((r_state == ST_SWAP) && !w_zero && w_slot_free);
  assign en_ab     = w_mac_beat;
  assign en_c      = w_fire;
  assign issng_a   = r_sgn_a;
  assign issng_b   = r_sgn_b;
  assign c_zero    = ((r_state == ST_SWAP) || (r_state == ST_FLUSH)) && w_zero;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err_op    = r_err_op;
  assign dbg_state = r_state;

endmodule
